// File: rtl/int_exec_unit.sv
// int_exec_unit: one-deep integer execute stage with x86 flags, branch resolve and valid/ready on both sides.
// Define ALU_MUL_EN to build the iterative radix-2 shift-add multiplier for op 10; otherwise op 10 is illegal.
module int_exec_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [3:0]         cond,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   next_rip,
  input  logic [WIDTH-1:0]   disp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               wr_en,
  output logic [63:0]        rflags,
  output logic               branch,
  output logic               branch_taken,
  output logic [WIDTH-1:0]   branch_rip,
  output logic               err
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned RW  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SAR = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
`endif
  localparam logic [3:0] OP_JCC = 4'd11;
  localparam logic [3:0] OP_JMP = 4'd12;

  typedef struct packed {
    logic of;
    logic sf;
    logic zf;
    logic pf;
    logic cf;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
`ifdef ALU_MUL_EN
    , MUL = 2'd2
`endif
  } state_t;

  state_t state, state_nxt, iss_state;
  flags_t flags_q, pend_q, eff_flags, iss_flags;

  logic             fire, accept, upd_zsp;
  logic [CW-1:0]    sh_cnt;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, sar_w;
  logic [RW-1:0]    iss_result;
  logic [WIDTH-1:0] iss_rip;
  logic             iss_wr, iss_br, iss_taken, iss_err;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q;
  logic [CW-1:0]    mul_cnt;
  logic [WIDTH:0]   mul_sum;
  logic             mul_hi_nz;
`endif

  // HOLD also accepts when the held result leaves on the same edge: 1 op/cycle plus flag bypass.
  assign out_valid = (state == HOLD);
  assign in_ready  = ((state == IDLE) || (state == HOLD)) && (!out_valid || out_ready);
  assign fire      = in_valid && in_ready;
  assign accept    = out_valid && out_ready;
  assign eff_flags = accept ? pend_q : flags_q;
  assign sh_cnt    = b[CW-1:0];

  assign rflags = {52'b0, flags_q.of, 3'b0, flags_q.sf, flags_q.zf, 3'b0, flags_q.pf, 1'b0, flags_q.cf};

  // x86 condition codes: pairs share a base test, cc[0] inverts it.
  function automatic logic cond_hit(input logic [3:0] cc, input flags_t f);
    logic t;
    t = 1'b0;
    case (cc[3:1])
      3'd0: t = f.of;
      3'd1: t = f.cf;
      3'd2: t = f.zf;
      3'd3: t = f.cf | f.zf;
      3'd4: t = f.sf;
      3'd5: t = f.pf;
      3'd6: t = f.sf ^ f.of;
      3'd7: t = f.zf | (f.sf ^ f.of);
      default: t = 1'b0;
    endcase
    return t ^ cc[0];
  endfunction

  // Result, flags and branch outcome for the op being issued this cycle.
  always_comb begin
    add_w      = {1'b0, a} + {1'b0, b};
    sub_w      = {1'b0, a} - {1'b0, b};
    shl_w      = {1'b0, a} << sh_cnt;
    shr_w      = {a, 1'b0} >> sh_cnt;
    sar_w      = $signed({a, 1'b0}) >>> sh_cnt;
    iss_result = '0;
    iss_flags  = eff_flags;
    iss_wr     = 1'b0;
    iss_br     = 1'b0;
    iss_taken  = 1'b0;
    iss_err    = 1'b0;
    iss_state  = HOLD;
    upd_zsp    = 1'b0;
    case (op)
      OP_ADD: begin
        iss_result   = RW'(add_w[MSB:0]);
        iss_flags.cf = add_w[WIDTH];
        iss_flags.of = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
        upd_zsp      = 1'b1;
        iss_wr       = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        iss_result   = RW'(sub_w[MSB:0]);
        iss_flags.cf = sub_w[WIDTH];
        iss_flags.of = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
        upd_zsp      = 1'b1;
        iss_wr       = (op == OP_SUB);
      end
      OP_AND, OP_OR, OP_XOR: begin
        if (op == OP_AND)     iss_result = RW'(a & b);
        else if (op == OP_OR) iss_result = RW'(a | b);
        else                  iss_result = RW'(a ^ b);
        iss_flags.cf = 1'b0;
        iss_flags.of = 1'b0;
        upd_zsp      = 1'b1;
        iss_wr       = 1'b1;
      end
      OP_MOV: begin
        iss_result = RW'(b);
        iss_wr     = 1'b1;
      end
      OP_SHL, OP_SHR, OP_SAR: begin
        iss_result = RW'(a);
        iss_wr     = 1'b1;
        if (sh_cnt != '0) begin
          upd_zsp = 1'b1;
          if (op == OP_SHL) begin
            iss_result   = RW'(shl_w[MSB:0]);
            iss_flags.cf = shl_w[WIDTH];
            iss_flags.of = shl_w[MSB] ^ shl_w[WIDTH];
          end else if (op == OP_SHR) begin
            iss_result   = RW'(shr_w[WIDTH:1]);
            iss_flags.cf = shr_w[0];
            iss_flags.of = a[MSB];
          end else begin
            iss_result   = RW'(sar_w[WIDTH:1]);
            iss_flags.cf = sar_w[0];
            iss_flags.of = 1'b0;
          end
        end
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        iss_result = RW'(b);
        iss_wr     = 1'b1;
        iss_state  = MUL;
      end
`endif
      OP_JCC: begin
        iss_br    = 1'b1;
        iss_taken = cond_hit(cond, eff_flags);
      end
      OP_JMP: begin
        iss_br    = 1'b1;
        iss_taken = 1'b1;
      end
      default: iss_err = 1'b1;
    endcase
    if (upd_zsp) begin
      iss_flags.zf = (iss_result[MSB:0] == '0);
      iss_flags.sf = iss_result[MSB];
      iss_flags.pf = ~^iss_result[7:0];
    end
    iss_rip = iss_taken ? (next_rip + disp) : next_rip;
  end

`ifdef ALU_MUL_EN
  // Product lives in result: upper half accumulates, lower half shifts the multiplier out.
  assign mul_sum   = {1'b0, result[RW-1:WIDTH]} + (result[0] ? {1'b0, mcand_q} : '0);
  assign mul_hi_nz = |mul_sum[WIDTH:1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fire) state_nxt = iss_state;
      HOLD: if (out_ready) state_nxt = fire ? iss_state : IDLE;
`ifdef ALU_MUL_EN
      MUL:  if (mul_cnt == CW'(WIDTH - 1)) state_nxt = HOLD;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output/flag registers; committed flags move only when the held result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      wr_en        <= 1'b0;
      branch       <= 1'b0;
      branch_taken <= 1'b0;
      branch_rip   <= '0;
      err          <= 1'b0;
      flags_q      <= '0;
      pend_q       <= '0;
`ifdef ALU_MUL_EN
      mcand_q      <= '0;
      mul_cnt      <= '0;
`endif
    end else begin
      if (accept) flags_q <= pend_q;
      if (fire) begin
        result       <= iss_result;
        wr_en        <= iss_wr;
        branch       <= iss_br;
        branch_taken <= iss_taken;
        branch_rip   <= iss_rip;
        err          <= iss_err;
        pend_q       <= iss_flags;
`ifdef ALU_MUL_EN
        mcand_q      <= a;
        mul_cnt      <= '0;
`endif
      end
`ifdef ALU_MUL_EN
      else if (state == MUL) begin
        result  <= {mul_sum, result[MSB:1]};
        mul_cnt <= mul_cnt + CW'(1);
        if (mul_cnt == CW'(WIDTH - 1)) begin
          pend_q.cf <= mul_hi_nz;
          pend_q.of <= mul_hi_nz;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_int_exec_unit.sv
// tb_int_exec_unit: randomized + directed stimulus against an ISA-level reference model, scoreboard-checked.
module tb_int_exec_unit;

  localparam int unsigned W = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [3:0]     op = '0;
  logic [3:0]     cond = '0;
  logic [W-1:0]   a = '0, b = '0, next_rip = '0, disp = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           wr_en;
  logic [63:0]    rflags;
  logic           branch, branch_taken, err;
  logic [W-1:0]   branch_rip;

  int_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cond(cond), .a(a), .b(b), .next_rip(next_rip), .disp(disp),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .wr_en(wr_en),
    .rflags(rflags), .branch(branch), .branch_taken(branch_taken),
    .branch_rip(branch_rip), .err(err)
  );

  typedef struct {
    logic [127:0] res;
    logic         wr, br, tk, err;
    logic [63:0]  rip, fl;
    int           lat;
    int           icyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 1;
  bit          seen = 1'b0;
  logic [63:0] mflags = '0;
  logic [63:0] exp_committed = '0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready policy: 0 / 1 forced, 2 random (mostly ready).
  initial forever begin
    @(negedge clk);
    if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    else               out_ready = (rdy_mode == 1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Sequential ISA model: flags evolve in issue order, so a JCC sees every earlier op's flags.
  task automatic model(input logic [3:0] o, input logic [3:0] c, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] nr, input logic [63:0] dp, output exp_t e);
    logic cf, pf, zf, sf, of, zsp, hit;
    logic [64:0] wide;
    logic signed [64:0] sv;
    logic [63:0] tmp;
    int n;
    cf = mflags[0]; pf = mflags[2]; zf = mflags[6]; sf = mflags[7]; of = mflags[11];
    e.res = '0; e.wr = 0; e.br = 0; e.tk = 0; e.err = 0; e.rip = nr; e.lat = 1; e.icyc = 0;
    zsp = 0; hit = 0;
    n = int'(y[5:0]);
    case (o)
      4'd0: begin
        wide = 65'(x) + 65'(y); e.res = 128'(wide[63:0]); cf = wide[64];
        sv = 65'($signed(x)) + 65'($signed(y)); of = (sv != 65'($signed(wide[63:0])));
        zsp = 1; e.wr = 1;
      end
      4'd1, 4'd6: begin
        wide = 65'(x) - 65'(y); e.res = 128'(wide[63:0]); cf = (x < y);
        sv = 65'($signed(x)) - 65'($signed(y)); of = (sv != 65'($signed(wide[63:0])));
        zsp = 1; e.wr = (o == 4'd1);
      end
      4'd2: begin e.res = 128'(x & y); cf = 0; of = 0; zsp = 1; e.wr = 1; end
      4'd3: begin e.res = 128'(x | y); cf = 0; of = 0; zsp = 1; e.wr = 1; end
      4'd4: begin e.res = 128'(x ^ y); cf = 0; of = 0; zsp = 1; e.wr = 1; end
      4'd5: begin e.res = 128'(y); e.wr = 1; end
      4'd7, 4'd8, 4'd9: begin
        e.wr = 1; e.res = 128'(x);
        if (n != 0) begin
          zsp = 1;
          if (o == 4'd7) begin
            tmp = x << n; e.res = 128'(tmp); cf = x[64 - n]; of = tmp[63] ^ cf;
          end else if (o == 4'd8) begin
            tmp = x >> n; e.res = 128'(tmp); cf = x[n - 1]; of = x[63];
          end else begin
            tmp = $signed(x) >>> n; e.res = 128'(tmp); cf = x[n - 1]; of = 0;
          end
        end
      end
`ifdef ALU_MUL_EN
      4'd10: begin
        e.res = 128'(x) * 128'(y); cf = (e.res[127:64] != 0); of = cf; e.wr = 1; e.lat = 65;
      end
`endif
      4'd11: begin
        case (c)
          4'd0:  hit = of;        4'd1:  hit = !of;
          4'd2:  hit = cf;        4'd3:  hit = !cf;
          4'd4:  hit = zf;        4'd5:  hit = !zf;
          4'd6:  hit = cf || zf;  4'd7:  hit = !cf && !zf;
          4'd8:  hit = sf;        4'd9:  hit = !sf;
          4'd10: hit = pf;        4'd11: hit = !pf;
          4'd12: hit = (sf != of);
          4'd13: hit = (sf == of);
          4'd14: hit = zf || (sf != of);
          default: hit = !zf && (sf == of);
        endcase
        e.br = 1; e.tk = hit;
      end
      4'd12: begin e.br = 1; e.tk = 1; end
      default: e.err = 1;
    endcase
    if (zsp) begin
      zf = (e.res[63:0] == 0); sf = e.res[63]; pf = ($countones(e.res[7:0]) % 2 == 0);
    end
    if (e.tk) e.rip = nr + dp;
    mflags = '0;
    mflags[0] = cf; mflags[2] = pf; mflags[6] = zf; mflags[7] = sf; mflags[11] = of;
    e.fl = mflags;
  endtask

  // Present one op; returns #1 after the edge it was accepted on.
  task automatic issue(input logic [3:0] o, input logic [3:0] c, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] nr, input logic [63:0] dp);
    exp_t e;
    int guard;
    @(negedge clk);
    op = o; cond = c; a = x; b = y; next_rip = nr; disp = dp; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 300) begin
      @(negedge clk); #1; guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready 0 want 1");
      in_valid = 1'b0;
      return;
    end
    model(o, c, x, y, nr, dp, e);
    e.icyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    rdy_mode = 1;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 500) begin
      @(negedge clk); #3; g++;
    end
    if (sb.size() != 0 || out_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d pending want 0", sb.size());
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, 128'(out_valid), 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_rflags"}, 128'(rflags), 0);
    chk({tag, "_branch"}, 128'({branch, branch_taken}), 0);
    chk({tag, "_err_wr"}, 128'({err, wr_en}), 0);
    chk({tag, "_in_ready"}, 128'(in_ready), 1);
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 255));
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      default: return 64'h7FFF_FFFF_FFFF_FFFF ^ 64'($urandom_range(0, 3));
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expected entry.
  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n) begin
      chk("rflags_committed", 128'(rflags), 128'(exp_committed));
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: out_valid 1 want 0");
        end else begin
          e = sb[0];
          if (!seen) begin
            chk("latency", 128'(cyc - e.icyc), 128'(e.lat));
            seen = 1'b1;
          end
          chk("result", result, e.res);
          chk("wr_en", 128'(wr_en), 128'(e.wr));
          chk("err", 128'(err), 128'(e.err));
          chk("branch", 128'(branch), 128'(e.br));
          if (e.br) begin
            chk("branch_taken", 128'(branch_taken), 128'(e.tk));
            chk("branch_rip", 128'(branch_rip), 128'(e.rip));
          end
          if (!out_ready) chk("in_ready_stall", 128'(in_ready), 0);
          else begin
            exp_committed = e.fl;
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run still active at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [63:0]  saved;
    logic [127:0] exp_mul;
    logic [3:0]   o;
    int           g;
    exp_mul = 128'h1_0000_0000_0000_0000;

    repeat (2) @(negedge clk);
    #3 chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD wrap to zero
    drain();
    issue(4'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    chk("add_result", result, 0);
    chk("add_wr_en", 128'(wr_en), 1);
    chk("add_out_valid", 128'(out_valid), 1);
    drain();
    chk("add_rflags", 128'(rflags), 128'(64'h45));

    // MUL 2^32 * 2^32
    issue(4'd10, 4'd0, 64'h1_0000_0000, 64'h1_0000_0000, 0, 0);
    g = 0;
    while (!out_valid && g < 200) begin @(negedge clk); #3; g++; end
`ifdef ALU_MUL_EN
    chk("mul_result", result, exp_mul);
    drain();
    chk("mul_rflags", 128'(rflags), 128'(64'h845));
`else
    chk("mul_illegal_err", 128'({err, wr_en}), 128'(2'b10));
    drain();
    chk("mul_illegal_rflags", 128'(rflags), 128'(64'h45));
`endif

    // CMP then JO issued on the CMP's commit edge
    issue(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    issue(4'd11, 4'd0, 0, 0, 64'h40_0100, 64'h20);
    chk("jo_taken", 128'({branch, branch_taken}), 128'(2'b11));
    chk("jo_rip", 128'(branch_rip), 128'(64'h40_0120));
    chk("cmp_rflags", 128'(rflags), 128'(64'h885));
    drain();

    // OR held for 5 cycles
    saved = rflags;
    rdy_mode = 0;
    issue(4'd3, 4'd0, 64'hF0, 64'h0F, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #3;
      chk("hold_result", result, 128'hFF);
      chk("hold_in_ready", 128'(in_ready), 0);
      chk("hold_rflags", 128'(rflags), 128'(saved));
    end
    drain();
    chk("or_rflags", 128'(rflags), 128'(64'h4));

    // SHL by 1, then by a count whose low bits are 0
    issue(4'd7, 4'd0, 64'h8000_0000_0000_0001, 64'd1, 0, 0);
    chk("shl_result", result, 128'h2);
    drain();
    chk("shl_rflags", 128'(rflags), 128'(64'h801));
    issue(4'd7, 4'd0, 64'h8000_0000_0000_0001, 64'd64, 0, 0);
    chk("shl0_result", result, 128'h8000_0000_0000_0001);
    drain();
    chk("shl0_rflags", 128'(rflags), 128'(64'h801));

    // illegal op
    issue(4'd14, 4'd0, 64'd5, 64'd6, 0, 0);
    chk("illegal_err_wr", 128'({err, wr_en}), 128'(2'b10));
    chk("illegal_result", result, 0);
    drain();
    chk("illegal_rflags", 128'(rflags), 128'(64'h801));

    // randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'd10 && $urandom_range(0, 5) != 0) o = 4'($urandom_range(0, 9));
      issue(o, 4'($urandom_range(0, 15)), rnd_val(),
            ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 70)) : rnd_val(),
            rnd_val(), rnd_val());
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    drain();

    // reset pulse during a MUL aborts it
    issue(4'd10, 4'd0, 64'd3, 64'd7, 0, 0);
    repeat (10) @(negedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    seen = 1'b0;
    mflags = '0;
    exp_committed = '0;
    #1 chk_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 4'd0, 64'd2, 64'd3, 0, 0);
    chk("post_reset_add", result, 128'd5);
    drain();
    chk("post_reset_rflags", 128'(rflags), 128'(64'h4));

    chk("scoreboard_empty", 128'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
